// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: widths, NOP encoding, fetch FSM encoding and
// the IF/ID register layout reused by later pipeline registers.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: none; the memory is a combinational read, so imem_rdata reflects
// imem_addr within the same cycle and is always accepted (no valid/ready).
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register holding pc/pc4/instr/valid with load, bubble and hold.
// Reset and bubble both leave a NOP with valid=0.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  // Bubble takes priority over load; neither asserted means hold.
  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      q <= IF_ID_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, redirect/stall control,
// misaligned-redirect pulse and a count of valid instructions fetched.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 stall_if,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_pc4,
  output logic [31:0]          if_id_instr,
  output logic                 if_id_valid,
  output logic                 misalign_fault,
  output logic [31:0]          fetch_count,
  output logic [0:0]           fsm_state
);

  if (XLEN != 32) begin : g_xlen_check
    $error("fetch_stage supports XLEN=32 only");
  end

  logic [31:0] pc;
  logic [0:0]  state;
  logic        ifid_load;
  logic        ifid_bubble;
  if_id_t      ifid_d;
  if_id_t      ifid_q;

  // Redirect beats stall: the EX instruction is older than anything in IF.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (state == ST_BOOT || redirect_valid) begin
      ifid_bubble = 1'b1;
    end else if (!stall_if) begin
      ifid_load = 1'b1;
    end
  end

  assign ifid_d = '{pc: pc, pc4: pc_plus4(pc), instr: imem.imem_rdata, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc             <= RESET_PC;
      state          <= ST_BOOT;
      misalign_fault <= 1'b0;
      fetch_count    <= 32'h0;
    end else begin
      state          <= ST_RUN;
      misalign_fault <= 1'b0;
      if (state == ST_RUN) begin
        if (redirect_valid) begin
          pc             <= {redirect_pc[31:2], 2'b00};
          misalign_fault <= |redirect_pc[1:0];
        end else if (!stall_if) begin
          pc          <= pc_plus4(pc);
          fetch_count <= fetch_count + 32'd1;
        end
      end
    end
  end

  assign imem.imem_addr = pc;
  assign if_id_pc       = ifid_q.pc;
  assign if_id_pc4      = ifid_q.pc4;
  assign if_id_instr    = ifid_q.instr;
  assign if_id_valid    = ifid_q.valid;
  assign fsm_state      = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a reference model feeds an expected queue on every
// driven cycle; scenario tasks add targeted inline checks.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int SBW = 32 * 6 + 2;

  logic        clk;
  int          checks;
  int          errors;

  // DUT 0: RESET_PC = 0
  logic        reset;
  logic        stall_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr, fetch_count;
  logic        if_id_valid, misalign_fault;
  logic [0:0]  fsm_state;
  fetch_stage_if bus0 ();
  assign bus0.imem_rdata = ~bus0.imem_addr;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem(bus0.master), .stall_if(stall_if),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .misalign_fault(misalign_fault),
    .fetch_count(fetch_count), .fsm_state(fsm_state)
  );

  // DUT 1: RESET_PC at the top of the address space
  logic        reset_w;
  logic        stall_w;
  logic        redir_w;
  logic [31:0] rpc_w;
  logic [31:0] w_pc, w_pc4, w_instr, w_count;
  logic        w_valid, w_fault;
  logic [0:0]  w_state;
  fetch_stage_if bus1 ();
  assign bus1.imem_rdata = ~bus1.imem_addr;

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset_w), .imem(bus1.master), .stall_if(stall_w),
    .redirect_valid(redir_w), .redirect_pc(rpc_w),
    .if_id_pc(w_pc), .if_id_pc4(w_pc4), .if_id_instr(w_instr),
    .if_id_valid(w_valid), .misalign_fault(w_fault),
    .fetch_count(w_count), .fsm_state(w_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset = 1'b0; stall_if = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    reset_w = 1'b0; stall_w = 1'b0; redir_w = 1'b0; rpc_w = 32'h0;
  end

  // Reference model of DUT 0
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_count;
  logic        m_valid, m_fault, m_boot;
  logic [SBW-1:0] exp_q[$];

  task automatic m_bubble();
    m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_instr = 32'h0000_0013; m_valid = 1'b0;
  endtask

  // Driver: apply inputs for one cycle and push the model's post-edge state.
  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    @(negedge clk);
    reset = r; stall_if = s; redirect_valid = rv; redirect_pc = rp;
    if (!r) begin
      m_pc = 32'h0; m_boot = 1'b1; m_bubble(); m_fault = 1'b0; m_count = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_bubble(); m_fault = 1'b0;
    end else if (rv) begin
      m_pc = {rp[31:2], 2'b00}; m_bubble(); m_fault = |rp[1:0];
    end else if (s) begin
      m_fault = 1'b0;
    end else begin
      m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_instr = ~m_pc; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_count = m_count + 32'd1; m_fault = 1'b0;
    end
    exp_q.push_back({m_ifpc, m_ifpc4, m_instr, m_valid, m_fault, m_count, m_pc});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  always @(posedge clk) begin
    logic [SBW-1:0] e, o;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = {if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign_fault, fetch_count, bus0.imem_addr};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_state got %h exp %h", o, e);
      end
    end
  end

  task automatic test_reset();
    repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus0.imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0000_0013 ||
        fetch_count !== 32'h0 || fsm_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got addr=%h v=%b instr=%h cnt=%h st=%b exp addr=0 v=0 instr=00000013 cnt=0 st=0",
               bus0.imem_addr, if_id_valid, if_id_instr, fetch_count, fsm_state);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_valid !== 1'b0 || bus0.imem_addr !== 32'h0 || fsm_state !== 1'b1) begin
      errors++;
      $display("FAIL boot_bubble got v=%b addr=%h st=%b exp v=0 addr=0 st=1", if_id_valid, bus0.imem_addr, fsm_state);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (if_id_pc !== 32'(i * 4) || if_id_valid !== 1'b1 || fetch_count !== 32'(i + 1)) begin
        errors++;
        $display("FAIL first_fetch got pc=%h v=%b cnt=%0d exp pc=%h v=1 cnt=%0d",
                 if_id_pc, if_id_valid, fetch_count, 32'(i * 4), i + 1);
      end
    end
  endtask

  task automatic test_stall();
    repeat (2) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (if_id_pc !== 32'h8 || bus0.imem_addr !== 32'hC || fetch_count !== 32'd3) begin
        errors++;
        $display("FAIL stall_hold got pc=%h addr=%h cnt=%0d exp pc=8 addr=c cnt=3", if_id_pc, bus0.imem_addr, fetch_count);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_pc !== 32'hC || fetch_count !== 32'd4 || bus0.imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_release got pc=%h cnt=%0d addr=%h exp pc=c cnt=4 addr=10", if_id_pc, fetch_count, bus0.imem_addr);
    end
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 1'b1, 32'h100);
    checks++;
    if (if_id_instr !== 32'h0000_0013 || if_id_valid !== 1'b0 || bus0.imem_addr !== 32'h100 || fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL redirect_squash got instr=%h v=%b addr=%h cnt=%0d exp instr=00000013 v=0 addr=100 cnt=4",
               if_id_instr, if_id_valid, bus0.imem_addr, fetch_count);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1 || if_id_instr !== ~32'h100) begin
      errors++;
      $display("FAIL redirect_target got pc=%h v=%b instr=%h exp pc=100 v=1 instr=%h", if_id_pc, if_id_valid, if_id_instr, ~32'h100);
    end
  endtask

  task automatic test_redirect_stall();
    drive(1'b1, 1'b1, 1'b1, 32'h200);
    checks++;
    if (bus0.imem_addr !== 32'h200 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_over_stall got addr=%h v=%b exp addr=200 v=0", bus0.imem_addr, if_id_valid);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_pc !== 32'h200 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_stall_target got pc=%h v=%b exp pc=200 v=1", if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 1'b1, 32'h102);
    checks++;
    if (bus0.imem_addr !== 32'h100 || misalign_fault !== 1'b1) begin
      errors++;
      $display("FAIL misalign_pulse got addr=%h fault=%b exp addr=100 fault=1", bus0.imem_addr, misalign_fault);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (misalign_fault !== 1'b0 || if_id_pc !== 32'h100) begin
      errors++;
      $display("FAIL misalign_clear got fault=%b pc=%h exp fault=0 pc=100", misalign_fault, if_id_pc);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b0, 1'b1, 1'b1, 32'h303);
    checks++;
    if (bus0.imem_addr !== 32'h0 || if_id_valid !== 1'b0 || misalign_fault !== 1'b0 || fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_wins got addr=%h v=%b fault=%b cnt=%0d exp addr=0 v=0 fault=0 cnt=0",
               bus0.imem_addr, if_id_valid, misalign_fault, fetch_count);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic        r, s, rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 19) != 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 4) == 0);
      rp = 32'($urandom_range(0, 32'h3FF));
      drive(r, s, rv, rp);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk); reset_w = 1'b0; redir_w = 1'b0; stall_w = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); reset_w = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (w_valid !== 1'b0 || bus1.imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_boot got v=%b addr=%h exp v=0 addr=fffffffc", w_valid, bus1.imem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_valid !== 1'b1 || bus1.imem_addr !== 32'h0 || w_count !== 32'd1) begin
      errors++;
      $display("FAIL wrap_pc4 got pc=%h pc4=%h v=%b addr=%h cnt=%0d exp pc=fffffffc pc4=0 v=1 addr=0 cnt=1",
               w_pc, w_pc4, w_valid, bus1.imem_addr, w_count);
    end
    @(posedge clk); #1;
    checks++;
    if (w_pc !== 32'h0 || w_pc4 !== 32'h4) begin
      errors++;
      $display("FAIL wrap_next got pc=%h pc4=%h exp pc=0 pc4=4", w_pc, w_pc4);
    end
    @(negedge clk); reset_w = 1'b0; redir_w = 1'b1; rpc_w = 32'h41;
    @(posedge clk); #1;
    checks++;
    if (w_valid !== 1'b0 || w_pc !== 32'h0 || w_pc4 !== 32'h0 || w_instr !== 32'h0000_0013 ||
        w_fault !== 1'b0 || w_count !== 32'h0 || bus1.imem_addr !== 32'hFFFF_FFFC || w_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_redirect got v=%b pc=%h pc4=%h instr=%h fault=%b cnt=%0d addr=%h st=%b exp reset values",
               w_valid, w_pc, w_pc4, w_instr, w_fault, w_count, bus1.imem_addr, w_state);
    end
    @(negedge clk); redir_w = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misalign();
    test_reset_mid_stall();
    test_random();
    test_wrap();
    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d entries left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
